// File: rtl/memory_map_pkg.sv
// memory_map_pkg: shared region/state types and address-map constants for memory_mapper
package memory_map_pkg;
  typedef enum logic [1:0] {RGN_ROM, RGN_RAM, RGN_IO, RGN_UNMAPPED} region_e;
  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_IO_WAIT, S_RESP} state_e;
  localparam logic [15:0] ROM_BASE = 16'h0000;
  localparam logic [15:0] RAM_BASE = 16'h8000;
  localparam logic [15:0] IO_BASE = 16'hC000;
  localparam logic [15:0] DEAD_WORD = 16'hDEAD;
endpackage

// File: rtl/memory_mapper_if.sv
// memory_mapper_if: CPU-side read/write request bus of memory_mapper
// master drives rd_req/rd_addr and wr_req/wr_addr/wr_data; slave returns rd_ready/rd_data/rd_valid
interface memory_mapper_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic rd_req, rd_ready, rd_valid, wr_req;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data, wr_data;
  modport master(output rd_req, rd_addr, wr_req, wr_addr, wr_data, input rd_ready, rd_data, rd_valid);
  modport slave(input rd_req, rd_addr, wr_req, wr_addr, wr_data, output rd_ready, rd_data, rd_valid);
endinterface

// File: rtl/memory_decode.sv
// memory_decode: combinational address decoder, addr_i -> region_o and I/O channel ch_o
module memory_decode
  import memory_map_pkg::*;
#(
  parameter int N_IO = 4,
  parameter int IO_WIN_W = 10,
  localparam int CH_W = 14 - IO_WIN_W
)(
  input  logic [15:0]     addr_i,
  output region_e         region_o,
  output logic [CH_W-1:0] ch_o
);
  assign ch_o = addr_i[13:IO_WIN_W];
  always_comb
    region_o = addr_i[15] == ROM_BASE[15] ? RGN_ROM :
               addr_i[14] == RAM_BASE[14] ? RGN_RAM :
               int'(ch_o) >= N_IO ? RGN_UNMAPPED : RGN_IO;
endmodule

// File: rtl/memory_mapper.sv
// memory_mapper: routes CPU reads/writes to ROM, RAM or N_IO I/O channels with sticky bus error
// Ports: clock/reset_n, bus (read/write request interface), rom_*, ram_*, io_* device ports,
// err_clr/bus_error/err_addr error reporting.
module memory_mapper
  import memory_map_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int N_IO = 4,
  parameter int IO_WIN_W = 10,
  parameter int IO_TIMEOUT = 15,
  parameter int SHADOW_EN = 1
)(
  input  logic                   clock,
  input  logic                   reset_n,
  memory_mapper_if.slave         bus,
  output logic [14:0]            rom_addr,
  input  logic [DATA_W-1:0]      rom_q,
  output logic [13:0]            ram_rdaddr,
  output logic [13:0]            ram_wraddr,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_wren,
  input  logic [DATA_W-1:0]      ram_q,
  output logic [IO_WIN_W-1:0]    io_addr,
  output logic [DATA_W-1:0]      io_wdata,
  output logic [N_IO-1:0]        io_wen,
  output logic [N_IO-1:0]        io_ren,
  input  logic [N_IO*DATA_W-1:0] io_rdata,
  input  logic [N_IO-1:0]        io_rvalid,
  input  logic                   err_clr,
  output logic                   bus_error,
  output logic [ADDR_W-1:0]      err_addr
);
  localparam int CH_W = 14 - IO_WIN_W;
  localparam int TW = $clog2(IO_TIMEOUT + 1);
  state_e state_q, state_d;
  region_e rrgn, wrgn, rgn_q, rgn_d;
  logic [CH_W-1:0] rch, wch, ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [N_IO-1:0] ren_q, ren_d;
  logic err_q, err_d, accept, io_hit, tmo, rd_err, wr_err;
  memory_decode #(.N_IO(N_IO), .IO_WIN_W(IO_WIN_W)) u_rd_dec (.addr_i(bus.rd_addr), .region_o(rrgn), .ch_o(rch));
  memory_decode #(.N_IO(N_IO), .IO_WIN_W(IO_WIN_W)) u_wr_dec (.addr_i(bus.wr_addr), .region_o(wrgn), .ch_o(wch));
  always_comb begin
    accept = bus.rd_req && state_q == S_IDLE;
    io_hit = state_q == S_IO_WAIT && io_rvalid[ch_q];
    tmo = state_q == S_IO_WAIT && !io_hit && tmr_q == TW'(IO_TIMEOUT - 1);
    rd_err = (accept && rrgn == RGN_UNMAPPED) || tmo;
    wr_err = bus.wr_req && (wrgn == RGN_UNMAPPED || (wrgn == RGN_ROM && SHADOW_EN == 0));
    state_d = state_q;
    addr_d = addr_q;
    rgn_d = rgn_q;
    ch_d = ch_q;
    data_d = data_q;
    tmr_d = tmr_q == TW'(IO_TIMEOUT) ? tmr_q : tmr_q + 1'b1;
    ren_d = '0;
    case (state_q)
      S_IDLE: if (bus.rd_req) begin
        addr_d = bus.rd_addr;
        rgn_d = rrgn;
        ch_d = rch;
        tmr_d = '0;
        data_d = rrgn == RGN_UNMAPPED ? '0 : data_q;
        ren_d = rrgn == RGN_IO ? N_IO'(1) << rch : '0;
        state_d = rrgn == RGN_IO ? S_IO_WAIT : rrgn == RGN_UNMAPPED ? S_RESP : S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        data_d = rgn_q == RGN_ROM ? rom_q : ram_q;
        state_d = S_RESP;
      end
      S_IO_WAIT: if (io_hit || tmo) begin
        data_d = io_hit ? io_rdata[ch_q*DATA_W +: DATA_W] : DATA_W'(DEAD_WORD);
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = rd_err || wr_err ? 1'b1 : err_clr ? 1'b0 : err_q;
    err_addr_d = rd_err ? (tmo ? addr_q : bus.rd_addr) : wr_err ? bus.wr_addr : err_addr_q;
  end
  // Memories sample the live address in IDLE so data is ready one cycle after acceptance.
  assign rom_addr = state_q == S_IDLE ? bus.rd_addr[14:0] : addr_q[14:0];
  assign ram_rdaddr = state_q == S_IDLE ? bus.rd_addr[13:0] : addr_q[13:0];
  // Posted writes are combinational; gating with reset_n keeps strobes low while in reset.
  assign ram_wren = reset_n && bus.wr_req && wrgn == RGN_RAM;
  assign ram_wraddr = bus.wr_addr[13:0];
  assign ram_wdata = bus.wr_data;
  assign io_wdata = bus.wr_data;
  assign io_wen = !(reset_n && bus.wr_req) ? '0 :
                  wrgn == RGN_IO ? N_IO'(1) << wch :
                  wrgn == RGN_ROM && SHADOW_EN != 0 ? N_IO'(1) : '0;
  // io_addr is shared: a posted I/O write takes it for its single cycle.
  assign io_addr = |io_wen ? bus.wr_addr[IO_WIN_W-1:0] : addr_q[IO_WIN_W-1:0];
  assign io_ren = ren_q;
  assign bus.rd_ready = state_q == S_IDLE;
  assign bus.rd_valid = state_q == S_RESP;
  assign bus.rd_data = data_q;
  assign bus_error = err_q;
  assign err_addr = err_addr_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      rgn_q <= RGN_ROM;
      ch_q <= '0;
      data_q <= '0;
      tmr_q <= '0;
      ren_q <= '0;
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rgn_q <= rgn_d;
      ch_q <= ch_d;
      data_q <= data_d;
      tmr_q <= tmr_d;
      ren_q <= ren_d;
      err_q <= err_d;
      err_addr_q <= err_addr_d;
    end
endmodule
